// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, count limits
// and the active-low 7-segment digit patterns (segment order gfedcba).
package countdown_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [6:0] MAX_CS  = 7'd99;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anything outside 0..9 shows as blank rather than garbage.
  function automatic logic [6:0] seg7(input logic [6:0] digit);
    case (digit)
      7'd0:    seg7 = SEG_0;
      7'd1:    seg7 = SEG_1;
      7'd2:    seg7 = SEG_2;
      7'd3:    seg7 = SEG_3;
      7'd4:    seg7 = SEG_4;
      7'd5:    seg7 = SEG_5;
      7'd6:    seg7 = SEG_6;
      7'd7:    seg7 = SEG_7;
      7'd8:    seg7 = SEG_8;
      7'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/countdown_timer_tick_div.sv
// Tick divider: one-cycle strobe every TICK_DIV enabled cycles; clear restarts
// the phase so the first strobe lands exactly TICK_DIV cycles later.
module tick_div #(
  parameter int TICK_DIV = 10
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds/centiseconds countdown timer with 7-segment outputs.
// Optional blinking alarm display is enabled by defining TIMER_ALARM_BLINK_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic       start_stop,
  input  logic [5:0] preset_sec,
  input  logic [6:0] preset_cs,
  output logic [5:0] sec_out,
  output logic [6:0] cs_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       running,
  output logic       alarm
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;

  state_t state;
  logic   tick;
  logic   count_zero;
  logic   div_clear;
  logic   alarm_q;
  logic   blink_on;
  logic   blank;

  assign count_zero = (sec_out == 6'd0) && (cs_out == 7'd0);

  // Restart the divider whenever the FSM is about to enter RUN (load outranks start_stop).
  assign div_clear = start_stop && !load &&
                     (((state == IDLE) && !count_zero) || (state == PAUSE));

  tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (state == RUN),
    .clear    (div_clear),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      sec_out <= 6'd0;
      cs_out  <= 7'd0;
      running <= 1'b0;
      alarm_q <= 1'b0;
    end else if (load) begin
      state   <= IDLE;
      sec_out <= (preset_sec > MAX_SEC) ? MAX_SEC : preset_sec;
      cs_out  <= (preset_cs > MAX_CS) ? MAX_CS : preset_cs;
      running <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_stop && !count_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            if (cs_out == 7'd0) begin
              cs_out  <= MAX_CS;
              sec_out <= sec_out - 6'd1;
            end else begin
              cs_out  <= cs_out - 7'd1;
            end
            // The tick that lands on 00.00 finishes the countdown.
            if ((sec_out == 6'd0) && (cs_out == 7'd1)) begin
              state   <= DONE;
              running <= 1'b0;
              alarm_q <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (start_stop) begin
            state   <= IDLE;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMER_ALARM_BLINK_EN
  localparam int BLINK_TICKS = (TICK_HZ / 4 > 0) ? TICK_HZ / 4 : 1;

  logic        blink_tick;
  logic [15:0] blink_cnt;

  tick_div #(.TICK_DIV(TICK_DIV)) u_blink_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (1'b1),
    .clear    (state != DONE),
    .tick     (blink_tick)
  );

  // Phase is held at "on" outside DONE so every expiry starts visibly lit.
  always_ff @(posedge CLOCK_50) begin
    if (reset || (state != DONE)) begin
      blink_cnt <= 16'd0;
      blink_on  <= 1'b1;
    end else if (blink_tick) begin
      if (blink_cnt == 16'(BLINK_TICKS - 1)) begin
        blink_cnt <= 16'd0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  assign alarm = alarm_q && blink_on;
  assign blank = alarm_q && !blink_on;

  assign HEX0 = blank ? SEG_BLANK : seg7(cs_out % 7'd10);
  assign HEX1 = blank ? SEG_BLANK : seg7(cs_out / 7'd10);
  assign HEX2 = blank ? SEG_BLANK : seg7({1'b0, sec_out} % 7'd10);
  assign HEX3 = blank ? SEG_BLANK : seg7({1'b0, sec_out} / 7'd10);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer at CLK_HZ=1000, TICK_HZ=100.
module tb_countdown_timer;

  logic       CLOCK_50;
  logic       reset;
  logic       load;
  logic       start_stop;
  logic [5:0] preset_sec;
  logic [6:0] preset_cs;
  logic [5:0] sec_out;
  logic [6:0] cs_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       running;
  logic       alarm;

  int checks_total  = 0;
  int checks_passed = 0;

  countdown_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load       (load),
    .start_stop (start_stop),
    .preset_sec (preset_sec),
    .preset_cs  (preset_cs),
    .sec_out    (sec_out),
    .cs_out     (cs_out),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .running    (running),
    .alarm      (alarm)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Independent active-low gfedcba table for expected HEX values.
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: exp_seg = 7'h40;
      1: exp_seg = 7'h79;
      2: exp_seg = 7'h24;
      3: exp_seg = 7'h30;
      4: exp_seg = 7'h19;
      5: exp_seg = 7'h12;
      6: exp_seg = 7'h02;
      7: exp_seg = 7'h78;
      8: exp_seg = 7'h00;
      9: exp_seg = 7'h10;
      default: exp_seg = 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    else
      checks_passed++;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic ss, input logic [5:0] psec, input logic [6:0] pcs);
    load       = ld;
    start_stop = ss;
    preset_sec = psec;
    preset_cs  = pcs;
    step(1);
    load       = 1'b0;
    start_stop = 1'b0;
  endtask

  logic alarm_seen;

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    start_stop = 1'b0;
    preset_sec = 6'd0;
    preset_cs  = 7'd0;
    step(2);

    checkOutput("rst_sec", sec_out, 0);
    checkOutput("rst_cs", cs_out, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_alarm", alarm, 0);
    checkOutput("rst_hex0", HEX0, exp_seg(0));
    checkOutput("rst_hex3", HEX3, exp_seg(0));
    reset = 1'b0;
    step(1);

    // Out-of-range preset saturates to 59.99
    applyStimulus(1'b1, 1'b0, 6'd63, 7'd120);
    checkOutput("sat_sec", sec_out, 59);
    checkOutput("sat_cs", cs_out, 99);
    checkOutput("sat_hex3", HEX3, exp_seg(5));
    checkOutput("sat_hex2", HEX2, exp_seg(9));
    checkOutput("sat_hex1", HEX1, exp_seg(9));
    checkOutput("sat_hex0", HEX0, exp_seg(9));

    // 00.03 countdown to DONE
    applyStimulus(1'b1, 1'b0, 6'd0, 7'd3);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    checkOutput("cd_run0", running, 1);
    step(9);
    checkOutput("cd_cs_at9", cs_out, 3);
    step(1);
    checkOutput("cd_cs_at10", cs_out, 2);
    step(10);
    checkOutput("cd_cs_at20", cs_out, 1);
    step(9);
    checkOutput("cd_alarm_at29", alarm, 0);
    step(1);
    checkOutput("cd_cs_at30", cs_out, 0);
    checkOutput("cd_alarm_at30", alarm, 1);
    checkOutput("cd_running_at30", running, 0);
    checkOutput("cd_hex0_done", HEX0, exp_seg(0));
    step(15);
    checkOutput("cd_no_wrap", cs_out, 0);
    checkOutput("cd_alarm_held", alarm, 1);

    // start_stop in DONE returns to IDLE at 00.00; start_stop there is ignored
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    checkOutput("done_idle_alarm", alarm, 0);
    checkOutput("done_idle_cs", cs_out, 0);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    checkOutput("zero_start_running", running, 0);
    step(15);
    checkOutput("zero_start_alarm", alarm, 0);
    checkOutput("zero_start_cs", cs_out, 0);

    // 01.00 borrow to 00.99
    applyStimulus(1'b1, 1'b0, 6'd1, 7'd0);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    step(10);
    checkOutput("brw_sec", sec_out, 0);
    checkOutput("brw_cs", cs_out, 99);
    checkOutput("brw_hex3", HEX3, exp_seg(0));
    checkOutput("brw_hex2", HEX2, exp_seg(0));
    checkOutput("brw_hex1", HEX1, exp_seg(9));
    checkOutput("brw_hex0", HEX0, exp_seg(9));

    // Pause after 25 cycles, hold 100, resume
    applyStimulus(1'b1, 1'b0, 6'd10, 7'd0);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    step(24);
    checkOutput("pz_pre_cs", cs_out, 98);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    checkOutput("pz_running", running, 0);
    step(100);
    checkOutput("pz_frozen_sec", sec_out, 9);
    checkOutput("pz_frozen_cs", cs_out, 98);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    checkOutput("pz_resumed", running, 1);
    step(9);
    checkOutput("pz_cs_at9", cs_out, 98);
    step(1);
    checkOutput("pz_cs_at10", cs_out, 97);

    // load beats start_stop while running
    applyStimulus(1'b1, 1'b1, 6'd0, 7'd42);
    checkOutput("lw_running", running, 0);
    checkOutput("lw_sec", sec_out, 0);
    checkOutput("lw_cs", cs_out, 42);
    step(15);
    checkOutput("lw_cs_idle", cs_out, 42);

    // reset mid-run aborts without DONE
    applyStimulus(1'b1, 1'b0, 6'd0, 7'd7);
    applyStimulus(1'b0, 1'b1, 6'd0, 7'd0);
    step(20);
    checkOutput("ra_pre_cs", cs_out, 5);
    reset = 1'b1;
    step(1);
    checkOutput("ra_running", running, 0);
    checkOutput("ra_cs", cs_out, 0);
    checkOutput("ra_alarm", alarm, 0);
    reset = 1'b0;
    alarm_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      alarm_seen = alarm_seen | alarm;
    end
    checkOutput("ra_no_done", alarm_seen, 0);
    checkOutput("ra_idle_running", running, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
